// File: rtl/jala_lcd_pkg.sv
// Shared types, LCD command bytes and the hex-to-ASCII helper for the JALA
// HD44780 display stage.
package jala_lcd_pkg;

  localparam int CYC_W = 20;
  localparam logic [CYC_W-1:0] SETUP_CYC = 20'd2;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_NIB,
    ST_INIT_CMD,
    ST_IDLE,
    ST_REFRESH
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_E_HI,
    PH_GAP
  } nib_phase_t;

  localparam logic [7:0] FUNC_SET = 8'h28;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;

  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one 4-bit nibble onto the LCD bus: setup, E pulse, then a gap.
// With strobe=0 it only runs the gap, so every wait shares the one counter.
module lcd_nibble_writer
  import jala_lcd_pkg::*;
#(
  parameter int E_HI_CYC = 12
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             go,
  input  logic             strobe,
  input  logic [3:0]       nibble,
  input  logic             rs,
  input  logic [CYC_W-1:0] gap_cyc,
  output logic             done,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic [3:0]       lcd_d
);

  localparam logic [CYC_W-1:0] E_HI_W = CYC_W'(E_HI_CYC);

  nib_phase_t       phase_q, phase_n;
  logic [CYC_W-1:0] cnt_q, cnt_n, gap_q, gap_n;
  logic             e_n, rs_n, done_n;
  logic [3:0]       d_n;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    phase_n = phase_q;
    cnt_n   = cnt_q;
    gap_n   = gap_q;
    e_n     = lcd_e;
    rs_n    = lcd_rs;
    d_n     = lcd_d;
    done_n  = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        if (go) begin
          gap_n = gap_cyc;
          if (strobe) begin
            d_n     = nibble;
            rs_n    = rs;
            phase_n = PH_SETUP;
            cnt_n   = SETUP_CYC - 1'b1;
          end else begin
            phase_n = PH_GAP;
            cnt_n   = gap_cyc - 1'b1;
          end
        end
      end
      PH_SETUP: begin
        if (cnt_q == '0) begin
          phase_n = PH_E_HI;
          cnt_n   = E_HI_W - 1'b1;
          e_n     = 1'b1;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      PH_E_HI: begin
        if (cnt_q == '0) begin
          phase_n = PH_GAP;
          cnt_n   = gap_q - 1'b1;
          e_n     = 1'b0;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      PH_GAP: begin
        if (cnt_q == '0) begin
          phase_n = PH_IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: phase_n = PH_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      lcd_e   <= 1'b0;
      lcd_rs  <= 1'b0;
      lcd_d   <= 4'h0;
      done    <= 1'b0;
    end else begin
      phase_q <= phase_n;
      cnt_q   <= cnt_n;
      gap_q   <= gap_n;
      lcd_e   <= e_n;
      lcd_rs  <= rs_n;
      lcd_d   <= d_n;
      done    <= done_n;
    end
  end

endmodule

// File: rtl/lcd_hex_display.sv
// Shows the last written 16-bit value as four hex chars on LCD line 1.
// Optional LCD_LINE2_EN adds line2_data, rendered on line 2 each refresh.
module lcd_hex_display
  import jala_lcd_pkg::*;
#(
  parameter int PWRUP_CYC   = 750000,
  parameter int INIT1_CYC   = 205000,
  parameter int INIT2_CYC   = 5000,
  parameter int E_HI_CYC    = 12,
  parameter int NIB_GAP_CYC = 50,
  parameter int CMD_CYC     = 2000,
  parameter int CLR_CYC     = 82000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        wr,
  input  logic [15:0] data,
`ifdef LCD_LINE2_EN
  input  logic [15:0] line2_data,
`endif
  output logic        ready,
  output logic        sf_ce,
  output logic        sf_oe,
  output logic        sf_we,
  output logic        lcd_rw,
  output logic        lcd_rs,
  output logic        lcd_E,
  output logic [3:0]  lcd_D
);

  localparam logic [CYC_W-1:0] PWRUP_W   = CYC_W'(PWRUP_CYC);
  localparam logic [CYC_W-1:0] INIT1_W   = CYC_W'(INIT1_CYC);
  localparam logic [CYC_W-1:0] INIT2_W   = CYC_W'(INIT2_CYC);
  localparam logic [CYC_W-1:0] NIB_GAP_W = CYC_W'(NIB_GAP_CYC);
  localparam logic [CYC_W-1:0] CMD_W     = CYC_W'(CMD_CYC);
  localparam logic [CYC_W-1:0] CLR_W     = CYC_W'(CLR_CYC);
`ifdef LCD_LINE2_EN
  localparam logic [3:0] LAST_REFRESH = 4'd9;
`else
  localparam logic [3:0] LAST_REFRESH = 4'd4;
`endif

  lcd_state_t  state_q, state_n;
  logic [3:0]  idx_q, idx_n;
  logic        half_q, half_n;
  logic        issued_q, issued_n;
  logic        pending_q;
  logic [15:0] pend_val_q, shown_q;
`ifdef LCD_LINE2_EN
  logic [15:0] pend2_q, shown2_q;
`endif

  logic             go, strobe, nib_rs, nib_done, cur_rs, is_byte;
  logic [3:0]       nib, last_idx, pos;
  logic [7:0]       cur_byte;
  logic [15:0]      src;
  logic [CYC_W-1:0] gap, byte_gap;

  assign sf_ce  = 1'b1;
  assign sf_oe  = 1'b1;
  assign sf_we  = 1'b1;
  assign lcd_rw = 1'b0;
  assign ready  = (state_q == ST_IDLE) && !pending_q;

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    half_n   = half_q;
    issued_n = issued_q;
    go       = 1'b0;
    strobe   = 1'b1;
    nib      = 4'h0;
    nib_rs   = 1'b0;
    gap      = NIB_GAP_W;
    cur_byte = 8'h00;
    cur_rs   = 1'b0;
    byte_gap = CMD_W;
    last_idx = 4'd0;
    is_byte  = 1'b0;
    src      = shown_q;
    pos      = idx_q;

    case (state_q)
      ST_PWRUP: begin
        strobe = 1'b0;
        gap    = PWRUP_W;
      end
      ST_INIT_NIB: begin
        nib = (idx_q == 4'd3) ? 4'h2 : 4'h3;
        gap = (idx_q == 4'd0) ? INIT1_W : (idx_q == 4'd1) ? INIT2_W : CMD_W;
      end
      ST_INIT_CMD: begin
        is_byte  = 1'b1;
        last_idx = 4'd3;
        case (idx_q)
          4'd0:    cur_byte = FUNC_SET;
          4'd1:    cur_byte = ENTRY;
          4'd2:    cur_byte = DISP_ON;
          default: cur_byte = CLEAR;
        endcase
        byte_gap = (idx_q == 4'd3) ? CLR_W : CMD_W;
      end
      ST_REFRESH: begin
        is_byte  = 1'b1;
        last_idx = LAST_REFRESH;
`ifdef LCD_LINE2_EN
        if (idx_q >= 4'd5) begin
          src = shown2_q;
          pos = idx_q - 4'd5;
        end
`endif
        // Position 0 of each line is the cursor-address command, the rest are chars.
        cur_rs = (pos != 4'd0);
        case (pos)
          4'd0:    cur_byte = (idx_q == 4'd0) ? LINE1 : LINE2;
          4'd1:    cur_byte = hex_to_ascii(src[15:12]);
          4'd2:    cur_byte = hex_to_ascii(src[11:8]);
          4'd3:    cur_byte = hex_to_ascii(src[7:4]);
          default: cur_byte = hex_to_ascii(src[3:0]);
        endcase
      end
      default: ;
    endcase

    if (is_byte) begin
      nib    = half_q ? cur_byte[3:0] : cur_byte[7:4];
      nib_rs = cur_rs;
      gap    = half_q ? byte_gap : NIB_GAP_W;
    end

    if (state_q == ST_IDLE) begin
      if (pending_q) begin
        state_n = ST_REFRESH;
        idx_n   = 4'd0;
        half_n  = 1'b0;
      end
    end else if (!issued_q) begin
      go       = 1'b1;
      issued_n = 1'b1;
    end else if (nib_done) begin
      issued_n = 1'b0;
      case (state_q)
        ST_PWRUP: begin
          state_n = ST_INIT_NIB;
          idx_n   = 4'd0;
        end
        ST_INIT_NIB: begin
          if (idx_q == 4'd3) begin
            state_n = ST_INIT_CMD;
            idx_n   = 4'd0;
            half_n  = 1'b0;
          end else begin
            idx_n = idx_q + 4'd1;
          end
        end
        default: begin
          if (!half_q) begin
            half_n = 1'b1;
          end else begin
            half_n = 1'b0;
            if (idx_q == last_idx) begin
              state_n = ST_IDLE;
              idx_n   = 4'd0;
            end else begin
              idx_n = idx_q + 4'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_PWRUP;
      idx_q      <= 4'd0;
      half_q     <= 1'b0;
      issued_q   <= 1'b0;
      pending_q  <= 1'b0;
      pend_val_q <= 16'h0000;
      shown_q    <= 16'h0000;
`ifdef LCD_LINE2_EN
      pend2_q    <= 16'h0000;
      shown2_q   <= 16'h0000;
`endif
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      half_q   <= half_n;
      issued_q <= issued_n;
      if (state_q == ST_IDLE && pending_q) begin
        shown_q   <= pend_val_q;
`ifdef LCD_LINE2_EN
        shown2_q  <= pend2_q;
`endif
        pending_q <= 1'b0;
      end
      // A strobe arriving as IDLE consumes the buffer re-arms it with the newer value.
      if (wr) begin
        pend_val_q <= data;
`ifdef LCD_LINE2_EN
        pend2_q    <= line2_data;
`endif
        pending_q  <= 1'b1;
      end
    end
  end

  lcd_nibble_writer #(.E_HI_CYC(E_HI_CYC)) u_nib (
    .CLK     (CLK),
    .RESET   (RESET),
    .go      (go),
    .strobe  (strobe),
    .nibble  (nib),
    .rs      (nib_rs),
    .gap_cyc (gap),
    .done    (nib_done),
    .lcd_e   (lcd_E),
    .lcd_rs  (lcd_rs),
    .lcd_d   (lcd_D)
  );

endmodule

// File: tb/tb_lcd_hex_display.sv
// Scoreboard bench for lcd_hex_display: expected nibbles are queued by the
// stimulus and compared by a monitor at every rising edge of lcd_E.
module tb_lcd_hex_display;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        wr;
  logic [15:0] data;
`ifdef LCD_LINE2_EN
  logic [15:0] line2_data;
`endif
  logic        ready, sf_ce, sf_oe, sf_we, lcd_rw, lcd_rs, lcd_E;
  logic [3:0]  lcd_D;

  lcd_hex_display #(
    .PWRUP_CYC(4), .INIT1_CYC(4), .INIT2_CYC(4), .E_HI_CYC(4),
    .NIB_GAP_CYC(4), .CMD_CYC(4), .CLR_CYC(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .wr(wr), .data(data),
`ifdef LCD_LINE2_EN
    .line2_data(line2_data),
`endif
    .ready(ready), .sf_ce(sf_ce), .sf_oe(sf_oe), .sf_we(sf_we),
    .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_E(lcd_E), .lcd_D(lcd_D)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_nib;
  logic       e_prev = 1'b0;

  // Monitor: every rising edge of lcd_E must match the head of the queue.
  always @(negedge CLK) begin
    if (lcd_E && !e_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_nibble actual rs=%0b d=%h required no strobe", lcd_rs, lcd_D);
      end else begin
        exp_nib = exp_q.pop_front();
        if ({lcd_rs, lcd_D} !== exp_nib) begin
          errors++;
          $display("FAIL nibble actual rs=%0b d=%h required rs=%0b d=%h",
                   lcd_rs, lcd_D, exp_nib[4], exp_nib[3:0]);
        end
      end
    end
    e_prev = lcd_E;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_nib(input logic rs, input logic [3:0] n);
    exp_q.push_back({rs, n});
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    push_nib(rs, b[7:4]);
    push_nib(rs, b[3:0]);
  endtask

  task automatic push_init();
    push_nib(1'b0, 4'h3);
    push_nib(1'b0, 4'h3);
    push_nib(1'b0, 4'h3);
    push_nib(1'b0, 4'h2);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h01);
  endtask

  task automatic push_line(input logic [7:0] cmd, input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
    push_byte(1'b0, cmd);
    push_byte(1'b1, c0);
    push_byte(1'b1, c1);
    push_byte(1'b1, c2);
    push_byte(1'b1, c3);
  endtask

  // Line-1 refresh; with line 2 enabled and line2_data held at 0 it also shows "0000".
  task automatic push_refresh(input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3);
    push_line(8'h80, c0, c1, c2, c3);
`ifdef LCD_LINE2_EN
    push_line(8'hC0, 8'h30, 8'h30, 8'h30, 8'h30);
`endif
  endtask

  task automatic pulse_wr(input logic [15:0] v);
    data = v;
    wr   = 1'b1;
    @(negedge CLK);
    wr   = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(name, {31'd0, ready}, 32'd1);
  endtask

  task automatic check_consts(input string tag);
    check({tag, "_sf"}, {29'd0, sf_ce, sf_oe, sf_we}, 32'h7);
    check({tag, "_rw"}, {31'd0, lcd_rw}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    RESET = 1'b1;
    wr    = 1'b0;
    data  = 16'h0000;
`ifdef LCD_LINE2_EN
    line2_data = 16'h0000;
`endif
    tick(3);

    // 1: reset state, then the init sequence
    check("rst_e", {31'd0, lcd_E}, 32'd0);
    check("rst_rs", {31'd0, lcd_rs}, 32'd0);
    check("rst_d", {28'd0, lcd_D}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check_consts("rst");
    push_init();
    RESET = 1'b0;
    wait_ready("init_ready", 3000);
    check("init_drained", exp_q.size(), 32'd0);
    check_consts("init");

    // 2: one write of 1A2F
    push_refresh(8'h31, 8'h41, 8'h32, 8'h46);
    pulse_wr(16'h1A2F);
    check("ready_low_after_wr", {31'd0, ready}, 32'd0);
    wait_ready("refresh_ready", 3000);
    check("refresh_drained", exp_q.size(), 32'd0);

    // 3: write during init is held until init completes
    RESET = 1'b1;
    tick(2);
    check("rst2_ready", {31'd0, ready}, 32'd0);
    push_init();
    push_refresh(8'h30, 8'h30, 8'h30, 8'h31);
    RESET = 1'b0;
    tick(10);
    check("init_busy", {31'd0, ready}, 32'd0);
    pulse_wr(16'h0001);
    wait_ready("init_wr_ready", 3000);
    check("init_wr_drained", exp_q.size(), 32'd0);

    // 4: writes mid-refresh collapse to one trailing refresh of the latest value
    push_refresh(8'h31, 8'h31, 8'h31, 8'h31);
    pulse_wr(16'h1111);
    tick(30);
    check("mid_refresh_busy", {31'd0, ready}, 32'd0);
    pulse_wr(16'hBEEF);
    pulse_wr(16'hCAFE);
    push_refresh(8'h43, 8'h41, 8'h46, 8'h45);
    wait_ready("latest_wins_ready", 3000);
    check("latest_wins_drained", exp_q.size(), 32'd0);
    tick(200);
    check("no_extra_refresh", {31'd0, ready}, 32'd1);

    // 5: reset during an E pulse, with a write on the same cycle as reset
    push_nib(1'b0, 4'h8);
    pulse_wr(16'h2222);
    n = 0;
    while (!lcd_E && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("e_high_seen", {31'd0, lcd_E}, 32'd1);
    RESET = 1'b1;
    wr    = 1'b1;
    data  = 16'hFFFF;
    @(posedge CLK);
    #1;
    check("e_drop_on_reset", {31'd0, lcd_E}, 32'd0);
    @(negedge CLK);
    wr = 1'b0;
    tick(2);
    check("rst3_ready", {31'd0, ready}, 32'd0);
    check("rst3_bus", {27'd0, lcd_rs, lcd_D}, 32'd0);
    check("rst3_drained", exp_q.size(), 32'd0);
    push_init();
    RESET = 1'b0;
    wait_ready("replay_ready", 3000);
    check("replay_drained", exp_q.size(), 32'd0);
    tick(200);
    check("reset_drops_wr", {31'd0, ready}, 32'd1);
    check_consts("end");

`ifdef LCD_LINE2_EN
    // 6: two-line refresh
    line2_data = 16'h1234;
    push_line(8'h80, 8'h30, 8'h30, 8'h46, 8'h46);
    push_line(8'hC0, 8'h31, 8'h32, 8'h33, 8'h34);
    pulse_wr(16'h00FF);
    wait_ready("line2_ready", 3000);
    check("line2_drained", exp_q.size(), 32'd0);
`endif

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
